// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// memory geometry and requester indices.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int MEM_WORDS  = 256;
    localparam int WORD_IDX_W = $clog2(MEM_WORDS);

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: one-hot grant, the requester that did not win last time has priority.
// Latency: combinational. Backpressure: none; the parent updates 'last' on accept.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // last=1 means the debug port won the previous contended round.
    always_comb begin
        grant          = 2'b00;
        grant[REQ_CPU] = req[REQ_CPU] & (~req[REQ_DBG] | last);
        grant[REQ_DBG] = req[REQ_DBG] & (~req[REQ_CPU] | ~last);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin sequencer in front of the data memory; optional DMEM_ARB_BOUNDS_CHECK_EN.
// Latency: accept at edge N, one-cycle memory access, response valid after edge N+1.
// Backpressure: one transaction in flight; req_ready low until the owner takes the response.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = dmem_pkg::MEM_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    import dmem_pkg::*;

    if ((1 << $clog2(MEM_WORDS)) != MEM_WORDS) begin : g_bad_depth
        $error("MEM_WORDS must be a power of two");
    end
    if (ADDR_W <= $clog2(MEM_WORDS) + 2) begin : g_bad_addr_w
        $error("ADDR_W too narrow for MEM_WORDS");
    end

    state_t              state;
    logic                last_grant;
    logic                grant_q;
    logic                we_q;
    logic [1:0]          grant;
    logic                sel;
    logic                accept;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req   (req_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign sel       = grant[REQ_DBG];
    assign sel_we    = sel ? req_we[REQ_DBG] : req_we[REQ_CPU];
    assign sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
    assign sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    // Gated by rst so nothing looks acceptable while reset is held.
    assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam int IDX_W = $clog2(MEM_WORDS);
    logic bad_addr;
    logic err_q;

    assign bad_addr = (|sel_addr[1:0]) | (|sel_addr[ADDR_W-1:IDX_W+2]);
    assign rsp_err  = err_q;
`else
    assign rsp_err  = 1'b0;
`endif

    // Strobes are flops set only for the ACCESS cycle, so async reset kills a store at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_q    <= sel;
                        last_grant <= sel;
                        we_q       <= sel_we;
                        mem_addr   <= sel_addr;
                        mem_wdata  <= sel_wdata;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
                        if (bad_addr) begin
                            state     <= RESP;
                            rsp_valid <= grant;
                            rsp_data  <= '0;
                            err_q     <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            mem_read  <= ~sel_we;
                            mem_write <= sel_we;
                            err_q     <= 1'b0;
                        end
`else
                        state     <= ACCESS;
                        mem_read  <= ~sel_we;
                        mem_write <= sel_we;
`endif
                    end
                end
                ACCESS: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    rsp_data  <= we_q ? '0 : mem_rdata;
                    rsp_valid <= grant_q ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant_q]) begin
                        rsp_valid <= 2'b00;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of transactions plus hand sequences for
// contention, reset during a store, and (with DMEM_ARB_BOUNDS_CHECK_EN) bad addresses.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int n_checks;
    int n_fail;

    typedef struct {
        int          r;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        err;
        int          stall;
    } vec_t;

    vec_t vecs [0:15];
    int   nv;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        logic [1:0] oh;
        oh        = (v.r == 1) ? 2'b10 : 2'b01;
        req_valid = oh;
        req_we    = v.we ? oh : 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        if (v.r == 1) begin
            req_addr[63:32]  = v.addr;
            req_wdata[63:32] = v.wdata;
        end else begin
            req_addr[31:0]   = v.addr;
            req_wdata[31:0]  = v.wdata;
        end
        rsp_ready = 2'b00;
        #1;
        check("req_ready_idle", {30'd0, req_ready}, {30'd0, oh});
        step();
        req_valid = 2'b00;
        check("req_ready_busy", {30'd0, req_ready}, 32'd0);
        if (!v.err) begin
            check("mem_write_access", {31'd0, mem_write}, {31'd0, v.we});
            check("mem_read_access", {31'd0, mem_read}, {31'd0, ~v.we});
            check("mem_addr_access", mem_addr, v.addr);
            if (v.we) check("mem_wdata_access", mem_wdata, v.wdata);
            step();
        end
        for (int s = 0; s <= v.stall; s++) begin
            if (s < v.stall) req_valid = ~oh;
            else             req_valid = 2'b00;
            #1;
            check("strobes_resp", {30'd0, mem_read, mem_write}, 32'd0);
            check("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
            check("rsp_data", rsp_data, v.exp);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, v.err});
            check("req_ready_resp", {30'd0, req_ready}, 32'd0);
            if (s < v.stall) step();
        end
        rsp_ready = oh;
        step();
        rsp_ready = 2'b00;
        check("rsp_valid_done", {30'd0, rsp_valid}, 32'd0);
    endtask

    logic [1:0] grants [0:7];
    int         ng;
    vec_t       ld;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 2'b00;

        nv = 0;
        vecs[nv++] = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 0};
        vecs[nv++] = '{1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0};
        vecs[nv++] = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 5};
        vecs[nv++] = '{1, 1'b1, 32'h0,   32'h000000A0, 32'h0,        1'b0, 0};
        vecs[nv++] = '{0, 1'b1, 32'h4,   32'h000000A4, 32'h0,        1'b0, 0};
        vecs[nv++] = '{1, 1'b1, 32'h20,  32'h000055AA, 32'h0,        1'b0, 0};
        vecs[nv++] = '{0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 2};
        vecs[nv++] = '{1, 1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 0};
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        vecs[nv++] = '{0, 1'b1, 32'h401, 32'h11111111, 32'h0,        1'b1, 0};
        vecs[nv++] = '{1, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 0};
        vecs[nv++] = '{0, 1'b1, 32'h12,  32'h22222222, 32'h0,        1'b1, 3};
        vecs[nv++] = '{1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 0};
`else
        vecs[nv++] = '{1, 1'b1, 32'h31,  32'h0BADC0DE, 32'h0,        1'b0, 0};
        vecs[nv++] = '{0, 1'b0, 32'h30,  32'h0,        32'h0BADC0DE, 1'b0, 0};
`endif

        // Reset state, with both requests raised to show nothing is offered.
        #12;
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        req_valid = 2'b00;
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < nv; i++) run_txn(vecs[i]);

        // Reset asserted during the ACCESS cycle of a store.
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {32'h0, 32'h20};
        req_wdata = {32'h0, 32'h12345678};
        step();
        req_valid = 2'b00;
        check("rst_mid_write_before", {31'd0, mem_write}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_write", {31'd0, mem_write}, 32'd0);
        check("rst_mid_addr", mem_addr, 32'd0);
        check("rst_mid_wdata", mem_wdata, 32'd0);
        check("rst_mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_mid_req_ready", {30'd0, req_ready}, 32'd0);
        step();
        rst = 1'b0;

        // Both requesters continuously valid: grants alternate starting with requester 0.
        req_we    = 2'b00;
        req_addr  = {32'h4, 32'h0};
        req_wdata = '0;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        ng = 0;
        for (int k = 0; k < 8; k++) grants[k] = 2'b00;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (req_ready != 2'b00 && ng < 8) grants[ng++] = req_ready;
            if (rsp_valid == 2'b01) check("rr_rsp_data0", rsp_data, 32'h000000A0);
            if (rsp_valid == 2'b10) check("rr_rsp_data1", rsp_data, 32'h000000A4);
            if (mem_read) check("rr_mem_addr", mem_addr, (grants[ng-1] == 2'b10) ? 32'h4 : 32'h0);
            @(posedge clk);
        end
        #1;
        req_valid = 2'b00;
        check("rr_grant_count_ge4", {31'd0, (ng >= 4)}, 32'd1);
        for (int k = 0; k < 4; k++)
            check("rr_grant_order", {30'd0, grants[k]}, (k % 2 == 1) ? 32'd2 : 32'd1);
        step();
        step();
        step();
        rsp_ready = 2'b00;
        check("rr_drained", {30'd0, rsp_valid}, 32'd0);

        // The aborted store must not have reached memory.
        ld = '{1, 1'b0, 32'h20, 32'h0, 32'h000055AA, 1'b0, 0};
        run_txn(ld);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, limit %0d ns", 50000);
        $fatal(1);
    end

endmodule
